// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: resolves E0/F0 prefixed make/break codes against a
// programmable key table, drives per-key level/pulse outputs and an event FIFO.
module ps2_key_tracker #(
  parameter int unsigned             NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES      = {9'h174, 9'h16B, 9'h076, 9'h029},
  parameter int unsigned             EVT_DEPTH      = 8,
  parameter int unsigned             TIMEOUT_CYCLES = 50000,
  localparam int unsigned            KW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                code_valid,
  input  logic [7:0]          code,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [KW-1:0]       evt_key,
  output logic                evt_make,
  output logic                evt_overflow
);

  localparam int unsigned AW = $clog2(EVT_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t  state, state_nxt;
  logic [TW-1:0] tmo_cnt;

  logic discard, is_e0, is_f0, code_done, code_ext, code_brk;

  logic [NUM_KEYS-1:0] hit, rise, fall, trans;
  logic [KW-1:0]       evt_idx;
  logic                idx_found;

  logic [KW:0]  mem [EVT_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         fifo_full, fifo_empty, push, pop, do_wr;

  // Byte classification and next-state selection
  always_comb begin
    discard   = code inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    is_e0     = (code == 8'hE0);
    is_f0     = (code == 8'hF0);
    code_ext  = (state == S_EXT) || (state == S_EXT_BRK);
    code_brk  = (state == S_BRK) || (state == S_EXT_BRK);
    code_done = code_valid && !discard && !is_e0 && !is_f0;
    state_nxt = S_IDLE;
    if (!discard) begin
      // E0 and F0 each latch their own flag; the order they arrive in is irrelevant
      if (is_e0)      state_nxt = code_brk ? S_EXT_BRK : S_EXT;
      else if (is_f0) state_nxt = code_ext ? S_EXT_BRK : S_BRK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
    end else if (code_valid) begin
      state   <= state_nxt;
      tmo_cnt <= '0;
    end else if (state != S_IDLE) begin
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state   <= S_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end
  end

  // Key table match; duplicate entries each update on their own
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      hit[i] = code_done && ({code_ext, code} == KEY_CODES[9*i +: 9]);
    rise  = code_brk ? '0 : (hit & ~key_down);
    fall  = code_brk ? (hit & key_down) : '0;
    trans = rise | fall;
    evt_idx   = '0;
    idx_found = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (trans[i] && !idx_found) begin
        evt_idx   = KW'(i);
        idx_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_down    <= (key_down | rise) & ~fall;
      key_press   <= rise;
      key_release <= fall;
    end
  end

  // Event FIFO: wrap-bit pointers; a full FIFO still accepts a push on a pop cycle
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push       = |trans;
    pop        = !fifo_empty && evt_ready;
    do_wr      = push && (!fifo_full || pop);
    evt_valid  = !fifo_empty;
    evt_key    = '0;
    evt_make   = 1'b0;
    if (!fifo_empty) begin
      evt_key  = mem[rd_ptr[AW-1:0]][KW:1];
      evt_make = mem[rd_ptr[AW-1:0]][0];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !reset)
      mem[wr_ptr[AW-1:0]] <= {evt_idx, ~code_brk};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && fifo_full && !pop) evt_overflow <= 1'b1;
    end
  end

endmodule
